m68k_region_decode: RTL and testbench

Parametrised, table-driven 68000 address decoder with per-region wait states and DTACK generation. It is the successor to the fixed, per-PCB combinational chip-select case block. Region bounds are loaded at runtime through a config port, so one instance serves every board variant. Chip selects are registered, and overlapping regions resolve by fixed priority. The block sits between the 68000 bus and the RAM/IO selects in the top level.

---
 rtl/m68k_region_decode_if.sv | 33 +++
 rtl/m68k_region_decode.sv | 150 +++++++++++++++
 tb/tb_m68k_region_decode.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_region_decode_if.sv
// 68000 bus side of the region decoder: CPU address/strobe in,
// registered chip selects and DTACK back out.
interface m68k_region_decode_if #(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24
);
  localparam int IW = $clog2(NUM_REGIONS);

  logic [ADDR_W-1:0]      m68k_a;
  logic                   m68k_as_n;
  logic [NUM_REGIONS-1:0] cs;
  logic                   dtack_n;
  logic                   unmapped;
  logic [IW-1:0]          active_idx;

  modport master (
    output m68k_a,
    output m68k_as_n,
    input  cs,
    input  dtack_n,
    input  unmapped,
    input  active_idx
  );

  modport slave (
    input  m68k_a,
    input  m68k_as_n,
    output cs,
    output dtack_n,
    output unmapped,
    output active_idx
  );
endinterface

// File: rtl/m68k_region_decode.sv
// Table-driven 68000 address decoder: runtime-loaded regions,
// fixed lowest-index priority, per-region wait states and DTACK.
module m68k_region_decode #(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int UNMAP_WAIT  = 8
) (
  input  logic                           clk_sys,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]              cfg_start,
  input  logic [ADDR_W-1:0]              cfg_end,
  input  logic [WAIT_W-1:0]              cfg_wait,
  input  logic                           cfg_en,
  m68k_region_decode_if.slave            bus
);

  localparam int IW = $clog2(NUM_REGIONS);
  localparam int UW = $clog2(UNMAP_WAIT + 1);
  localparam int CW = (WAIT_W > UW) ? WAIT_W : UW;
  localparam bit FULL = (NUM_REGIONS == (1 << IW));

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK
  } state_t;

  logic [ADDR_W-1:0]      t_start [NUM_REGIONS];
  logic [ADDR_W-1:0]      t_end   [NUM_REGIONS];
  logic [WAIT_W-1:0]      t_wait  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] t_en;

  logic                   idx_ok;
  logic [NUM_REGIONS-1:0] match;
  logic                   hit;
  logic [IW-1:0]          hit_idx;
  logic [WAIT_W-1:0]      hit_wait;

  state_t                 state;
  logic [ADDR_W-1:0]      addr_q;
  logic [CW-1:0]          cnt;
  logic [NUM_REGIONS-1:0] cs_q;
  logic                   dtack_q;
  logic                   unm_q;
  logic [IW-1:0]          idx_q;

  assign idx_ok = FULL ? 1'b1
                : (32'(cfg_idx) < 32'(NUM_REGIONS));

  // Only the enables need a reset; bounds are don't-care while disabled.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      t_en <= '0;
    end else if (cfg_we && idx_ok) begin
      t_en[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (cfg_we && idx_ok) begin
      t_start[cfg_idx] <= cfg_start;
      t_end[cfg_idx]   <= cfg_end;
      t_wait[cfg_idx]  <= cfg_wait;
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      match[k] = t_en[k]
              && (addr_q >= t_start[k])
              && (addr_q <= t_end[k]);
    end
  end

  // Scan downwards so the lowest matching index is the survivor.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (match[k]) hit_idx = IW'(k);
    end
  end

  assign hit_wait = t_wait[hit_idx];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      cnt     <= '0;
      cs_q    <= '0;
      dtack_q <= 1'b1;
      unm_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      unm_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cs_q    <= '0;
          dtack_q <= 1'b1;
          if (!bus.m68k_as_n) begin
            addr_q <= bus.m68k_a;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (bus.m68k_as_n) begin
            state <= S_IDLE;
          end else if (hit) begin
            cs_q  <= NUM_REGIONS'(1) << hit_idx;
            cnt   <= CW'(hit_wait);
            idx_q <= hit_idx;
            state <= (hit_wait == '0) ? S_ACK : S_WAIT;
          end else begin
            unm_q <= 1'b1;
            cnt   <= CW'(UNMAP_WAIT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.m68k_as_n) begin
            state <= S_IDLE;
          end else if (cnt <= CW'(1)) begin
            state <= S_ACK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ACK: begin
          if (bus.m68k_as_n) begin
            state <= S_IDLE;
          end else begin
            dtack_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.cs         = cs_q;
  assign bus.dtack_n    = dtack_q;
  assign bus.unmapped   = unm_q;
  assign bus.active_idx = idx_q;

endmodule

// File: tb/tb_m68k_region_decode.sv
// Randomised and directed bench for m68k_region_decode against
// a timeline model derived from the region table rules.
module tb_m68k_region_decode;

  localparam int NR = 16;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int UW = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [3:0]    cfg_idx;
  logic [AW-1:0] cfg_start;
  logic [AW-1:0] cfg_end;
  logic [WW-1:0] cfg_wait;
  logic          cfg_en;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] m_start [NR];
  logic [AW-1:0] m_end   [NR];
  int            m_wait  [NR];
  bit            m_en    [NR];

  int            p_idx;
  logic [AW-1:0] p_s;
  logic [AW-1:0] p_e;
  int            p_w;
  bit            p_en;

  m68k_region_decode_if #(.NUM_REGIONS(NR), .ADDR_W(AW)) bus ();

  m68k_region_decode #(
    .NUM_REGIONS(NR),
    .ADDR_W(AW),
    .WAIT_W(WW),
    .UNMAP_WAIT(UW)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_start(cfg_start),
    .cfg_end(cfg_end),
    .cfg_wait(cfg_wait),
    .cfg_en(cfg_en),
    .bus(bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NR; k++) m_en[k] = 1'b0;
  endtask

  task automatic model_wr();
    m_start[p_idx] = p_s;
    m_end[p_idx]   = p_e;
    m_wait[p_idx]  = p_w;
    m_en[p_idx]    = p_en;
  endtask

  task automatic drive_pend();
    cfg_idx   = 4'(p_idx);
    cfg_start = p_s;
    cfg_end   = p_e;
    cfg_wait  = WW'(p_w);
    cfg_en    = p_en;
  endtask

  task automatic set_pend(input int idx, input logic [AW-1:0] s,
                          input logic [AW-1:0] e, input int w,
                          input bit en);
    p_idx = idx;
    p_s   = s;
    p_e   = e;
    p_w   = w;
    p_en  = en;
  endtask

  task automatic cfg(input int idx, input logic [AW-1:0] s,
                     input logic [AW-1:0] e, input int w,
                     input bit en);
    set_pend(idx, s, e, w, en);
    drive_pend();
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    model_wr();
  endtask

  task automatic lookup(input logic [AW-1:0] a, output bit hit,
                        output int idx, output int w);
    hit = 1'b0;
    idx = 0;
    w   = 0;
    for (int k = 0; k < NR; k++) begin
      if (!hit && m_en[k] && a >= m_start[k] && a <= m_end[k]) begin
        hit = 1'b1;
        idx = k;
        w   = m_wait[k];
      end
    end
  endtask

  // AS is low for edges 0..L-1 relative to N and sampled high at N+L.
  // A pending table write lands at edge N+wr_at (wr_at < 0: none).
  task automatic access(input logic [AW-1:0] addr, input int L,
                        input int wr_at);
    bit      hit;
    bit      dec;
    int      idx;
    int      w;
    int      d;
    logic [NR-1:0] oh;
    logic [NR-1:0] e_cs;
    logic    e_dt;
    logic    e_un;
    if (wr_at == 0) model_wr();
    lookup(addr, hit, idx, w);
    dec = (L >= 2);
    d   = 2 + (hit ? w : UW);
    oh  = hit ? (NR'(1) << idx) : '0;
    drive_pend();
    bus.m68k_a    = addr;
    bus.m68k_as_n = 1'b0;
    cfg_we        = (wr_at == 0);
    for (int t = 0; t <= L + 1; t++) begin
      tick();
      e_cs = (dec && t >= 1 && t <= L) ? oh : '0;
      e_un = dec && !hit && t == 1;
      e_dt = !(dec && d < L && t >= d && t <= L);
      chk($sformatf("cs@%0d", t), bus.cs, e_cs);
      chk($sformatf("dtack_n@%0d", t), bus.dtack_n, e_dt);
      chk($sformatf("unmapped@%0d", t), bus.unmapped, e_un);
      if (e_cs != '0)
        chk($sformatf("active_idx@%0d", t), bus.active_idx, idx);
      cfg_we        = (t + 1 == wr_at);
      bus.m68k_as_n = (t + 1 >= L);
    end
    cfg_we = 1'b0;
    if (wr_at > 0) model_wr();
  endtask

  initial begin
    reset         = 1'b1;
    cfg_we        = 1'b0;
    cfg_idx       = '0;
    cfg_start     = '0;
    cfg_end       = '0;
    cfg_wait      = '0;
    cfg_en        = 1'b0;
    bus.m68k_a    = 24'h000100;
    bus.m68k_as_n = 1'b0;
    model_clear();
    set_pend(0, '0, '0, 0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_cs", bus.cs, '0);
      chk("rst_dtack_n", bus.dtack_n, 1'b1);
      chk("rst_unmapped", bus.unmapped, 1'b0);
      chk("rst_active_idx", bus.active_idx, '0);
    end
    reset         = 1'b0;
    bus.m68k_as_n = 1'b1;
    tick();

    access(24'h000100, 12, -1);

    cfg(0, 24'h000000, 24'h05FFFF, 0, 1'b1);
    access(24'h001234, 5, -1);

    cfg(3, 24'h060000, 24'h063FFF, 5, 1'b1);
    access(24'h063FFE, 10, -1);
    access(24'h064000, 12, -1);

    cfg(2, 24'h040000, 24'h04003F, 0, 1'b1);
    cfg(5, 24'h040000, 24'h04003F, 0, 1'b1);
    access(24'h040010, 4, -1);
    cfg(2, 24'h040000, 24'h04003F, 0, 1'b0);
    access(24'h040010, 4, -1);

    cfg(1, 24'h070000, 24'h07FFFF, 15, 1'b1);
    access(24'h070100, 4, -1);

    set_pend(1, 24'h080000, 24'h08FFFF, 2, 1'b1);
    access(24'h070200, 20, 3);
    access(24'h070200, 12, -1);
    access(24'h080010, 8, -1);

    set_pend(4, 24'h090000, 24'h09FFFF, 1, 1'b1);
    access(24'h090000, 6, 0);

    cfg(6, 24'h000200, 24'h0001FF, 0, 1'b1);
    access(24'h0A0000, 12, -1);

    bus.m68k_a    = 24'h001000;
    bus.m68k_as_n = 1'b0;
    tick();
    tick();
    chk("mid_pre_cs", bus.cs, 16'h0001);
    tick();
    tick();
    chk("mid_pre_dtack_n", bus.dtack_n, 1'b0);
    reset = 1'b1;
    tick();
    chk("mid_rst_cs", bus.cs, '0);
    chk("mid_rst_dtack_n", bus.dtack_n, 1'b1);
    chk("mid_rst_unmapped", bus.unmapped, 1'b0);
    chk("mid_rst_active_idx", bus.active_idx, '0);
    reset         = 1'b0;
    bus.m68k_as_n = 1'b1;
    model_clear();
    tick();
    access(24'h001000, 12, -1);

    for (int i = 0; i < 80; i++) begin
      int            L;
      int            wa;
      logic [AW-1:0] s;
      logic [AW-1:0] a;
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          s = AW'($urandom_range(0, 4095));
          cfg($urandom_range(0, NR - 1), s,
              s + AW'($urandom_range(0, 1024)) - AW'(64),
              $urandom_range(0, 15), $urandom_range(0, 3) != 0);
        end
      end
      L  = $urandom_range(1, 20);
      s  = AW'($urandom_range(0, 4095));
      set_pend($urandom_range(0, NR - 1), s,
               s + AW'($urandom_range(0, 1024)),
               $urandom_range(0, 15), 1'b1);
      wa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, L + 1) : -1;
      a  = ($urandom_range(0, 7) == 0) ? AW'($urandom)
                                        : AW'($urandom_range(0, 5200));
      access(a, L, wa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
